ram_sample_writer: RTL and testbench
====================================

Name: ram_sample_writer

Overview:
- Writer side of the 2048x16 single-port input sample RAM (address 11, data 16, wren, registered q).
- Accepts a valid/ready sample stream and writes it to consecutive RAM addresses from a programmable base.
- Paces writes to at most one per RATE_DIV clocks, matching the consumer, which steps one address every 16 clocks.
- Supports one-shot (stop at length) and circular (wrap) capture; sits between the ADC/sample front end and the RAM feeding the PID datapath.

Parameters:
- ADDR_W, 11: RAM address width.
- DATA_W, 16: sample width.
- RATE_DIV, 16: minimum clocks between successive accepted samples; must be at least 1.

Ports:
- clock  in  1  single clock; all logic is on posedge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; begins a capture when IDLE or DONE.
- circular  in  1  sampled at start; 1 = wrap and run until stop, 0 = one-shot.
- stop  in  1  one-cycle pulse; ends a capture after any in-flight write.
- base_addr  in  ADDR_W  first write address, sampled at start.
- length  in  ADDR_W+1  number of samples, 1..2048, sampled at start; 0 is treated as 2048.
- in_valid  in  1  upstream sample valid.
- in_data  in  DATA_W  upstream sample.
- in_ready  out  1  block can accept a sample this cycle.
- ram_address  out  ADDR_W  to RAM address.
- ram_data  out  DATA_W  to RAM data.
- ram_wren  out  1  to RAM wren.
- busy  out  1  high in WRITE state.
- done  out  1  one-cycle pulse when a capture completes.
- wrapped  out  1  sticky; set on the first wrap in circular mode, cleared at start.
- count  out  ADDR_W+1  samples written in the current capture; saturates at 2048 in circular mode.

Behaviour:
- Reset (synchronous, active-high) values:
  - state = IDLE.
  - in_ready, ram_wren, busy, done, wrapped = 0.
  - ram_address, ram_data, count = 0.
  - Pacing counter = 0.
  - Reset mid-capture aborts the capture immediately, with no further wren.
- States:
  - IDLE to WRITE on start.
  - WRITE to DONE when the write of the last sample issues (one-shot), or when stop is seen and no write is pending.
  - DONE to IDLE the next cycle, with done=1 for that one cycle.
  - start in DONE is honoured the same as in IDLE.
  - start while in WRITE is ignored.
- On start:
  - Latch base_addr as the write pointer, latch length and circular.
  - count = 0, wrapped = 0, pacing counter = 0.
- in_ready = (state == WRITE) and (pacing counter == 0) and not stop_pending and not last_accepted.
- Accept: a sample is accepted when in_valid and in_ready are both 1.
- Cycle after accept (latency 1, registered outputs):
  - ram_wren = 1, ram_address = write pointer, ram_data = accepted sample.
  - Write pointer increments modulo 2^ADDR_W; count increments.
  - Pacing counter loads RATE_DIV-1, then decrements to 0.
  - With RATE_DIV = 1, back-to-back accepts are allowed.
- ram_wren is high for exactly one cycle per accepted sample and 0 otherwise. ram_address and ram_data hold their last values when wren = 0.
- Address wrap: the pointer wraps 2047 to 0 regardless of base, in both modes.
- One-shot mode:
  - After `length` accepts, last_accepted is set and in_ready = 0.
  - The FSM enters DONE on the cycle the final wren is driven, so done asserts the cycle after the last wren.
- Circular mode:
  - Runs until stop.
  - wrapped is set when count would reach 2048 (the whole buffer is overwritten once); count then holds at 2048.
- stop:
  - Takes effect for new accepts in the same cycle: stop in an accept cycle blocks that accept.
  - A write already accepted still completes.
  - stop in IDLE or DONE is ignored.
  - stop in one-shot mode ends the capture early, with done pulsed as usual.
- start and stop in the same cycle while IDLE: start wins and stop is ignored.
- in_valid with in_ready = 0: the sample is not consumed; upstream holds it.
- busy = (state == WRITE).

Test Plan:
- Reset, then start with base=0, length=4, circular=0, RATE_DIV=16, and in_valid held with data 0x1000..0x1003 → four wren pulses at addresses 0..3, spaced 16 clocks; done pulses the cycle after the 4th wren; count = 4; no 5th write.
- base=2046, length=4, one-shot → writes land at addresses 2046, 2047, 0, 1; wrapped stays 0.
- circular=1, base=5, feed 2050 samples, then stop → wrapped = 1 after the 2048th write; count = 2048; the last two writes go to addresses 5 and 6; done pulses after stop.
- in_valid toggled 0/1 every 3 clocks, RATE_DIV=1, length=8 → exactly 8 wren pulses, each carrying the sample accepted the prior cycle; no wren when in_valid was low.
- Reset asserted mid-capture after 2 writes → all outputs return to 0 the next cycle; no further wren; a subsequent start begins from the newly latched base with count = 0.
- start while busy, length=0 (treated as 2048), and a stop in the same cycle as an accept → the start is ignored; length=0 yields 2048 writes; the blocked sample is not written and done follows.

Source files
------------

// File: rtl/ram_sample_writer.sv
// Writer side of the input sample RAM: paces a valid/ready sample stream into
// consecutive RAM addresses from a latched base, in one-shot or circular mode.
//
// state | meaning
// IDLE  | waiting for start
// WRITE | capture running, samples accepted at the paced rate
// DONE  | capture finished; done pulses on the following cycle
module ram_sample_writer #(
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 16,
  parameter int RATE_DIV = 16
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_circular,
  input  logic              i_stop,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [ADDR_W:0]   i_length,
  input  logic              i_in_valid,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_in_ready,
  output logic [ADDR_W-1:0] o_ram_address,
  output logic [DATA_W-1:0] o_ram_data,
  output logic              o_ram_wren,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_wrapped,
  output logic [ADDR_W:0]   o_count
);

  localparam int PACE_W = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
  localparam logic [PACE_W-1:0] PACE_LOAD = PACE_W'(RATE_DIV - 1);
  localparam logic [ADDR_W:0]   FULL      = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_ptr;
  logic [ADDR_W:0]     r_len;
  logic                r_circ;
  logic [ADDR_W:0]     r_count;
  logic [PACE_W-1:0]   r_pace;
  logic                r_last_acc;
  logic                r_wren;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data;
  logic                r_done;
  logic                r_wrapped;

  logic w_in_ready;
  logic w_accept;
  logic w_last;
  logic w_start;

  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // stop gates in_ready combinationally so it blocks an accept in its own cycle
  always_comb begin
    w_next     = r_state;
    w_in_ready = 1'b0;
    w_accept   = 1'b0;
    w_last     = 1'b0;
    w_start    = 1'b0;
    case (r_state)
      IDLE: begin
        w_start = i_start;
        if (i_start) w_next = WRITE;
      end
      WRITE: begin
        w_in_ready = (r_pace == '0) && !i_stop && !r_last_acc;
        w_accept   = w_in_ready && i_in_valid;
        w_last     = w_accept && !r_circ && ((r_count + 1'b1) == r_len);
        if (i_stop || w_last) w_next = DONE;
      end
      DONE: begin
        w_start = i_start;
        w_next  = i_start ? WRITE : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_ptr      <= '0;
      r_len      <= '0;
      r_circ     <= 1'b0;
      r_count    <= '0;
      r_pace     <= '0;
      r_last_acc <= 1'b0;
      r_wren     <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_done     <= 1'b0;
      r_wrapped  <= 1'b0;
    end else begin
      r_wren <= w_accept;
      r_done <= (r_state == DONE);
      if (w_start) begin
        r_ptr      <= i_base_addr;
        // zero and out-of-range lengths both mean the whole buffer
        r_len      <= ((i_length == '0) || (i_length > FULL)) ? FULL : i_length;
        r_circ     <= i_circular;
        r_count    <= '0;
        r_wrapped  <= 1'b0;
        r_pace     <= '0;
        r_last_acc <= 1'b0;
      end else if (w_accept) begin
        r_addr <= r_ptr;
        r_data <= i_in_data;
        r_ptr  <= r_ptr + 1'b1;
        r_pace <= PACE_LOAD;
        if (r_count != FULL) r_count <= r_count + 1'b1;
        if (r_circ && (r_count == FULL - 1'b1)) r_wrapped <= 1'b1;
        if (w_last) r_last_acc <= 1'b1;
      end else if (r_pace != '0) begin
        r_pace <= r_pace - 1'b1;
      end
    end
  end

  assign o_in_ready    = w_in_ready;
  assign o_ram_address = r_addr;
  assign o_ram_data    = r_data;
  assign o_ram_wren    = r_wren;
  assign o_busy        = (r_state == WRITE);
  assign o_done        = r_done;
  assign o_wrapped     = r_wrapped;
  assign o_count       = r_count;

endmodule

// File: tb/tb_ram_sample_writer.sv
// Bench for ram_sample_writer: one instance paced at 16 clocks, one at 1 clock,
// sharing stimulus; a table of one-shot captures plus directed corner sequences.
module tb_ram_sample_writer;

  logic        clk = 1'b0;
  logic        rst, start, circ, stop, in_valid;
  logic [10:0] base;
  logic [11:0] len;
  logic [15:0] in_data;

  logic        a_rdy, a_wren, a_busy, a_done, a_wrap;
  logic [10:0] a_addr;
  logic [15:0] a_data;
  logic [11:0] a_cnt;
  logic        b_rdy, b_wren, b_busy, b_done, b_wrap;
  logic [10:0] b_addr;
  logic [15:0] b_data;
  logic [11:0] b_cnt;

  logic        sel;
  logic        m_rdy, m_wren, m_busy, m_done, m_wrap;
  logic [10:0] m_addr;
  logic [15:0] m_data;
  logic [11:0] m_cnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ram_sample_writer #(.ADDR_W(11), .DATA_W(16), .RATE_DIV(16)) dut16 (
    .i_clock(clk), .i_reset(rst), .i_start(start), .i_circular(circ), .i_stop(stop),
    .i_base_addr(base), .i_length(len), .i_in_valid(in_valid), .i_in_data(in_data),
    .o_in_ready(a_rdy), .o_ram_address(a_addr), .o_ram_data(a_data), .o_ram_wren(a_wren),
    .o_busy(a_busy), .o_done(a_done), .o_wrapped(a_wrap), .o_count(a_cnt));

  ram_sample_writer #(.ADDR_W(11), .DATA_W(16), .RATE_DIV(1)) dut1 (
    .i_clock(clk), .i_reset(rst), .i_start(start), .i_circular(circ), .i_stop(stop),
    .i_base_addr(base), .i_length(len), .i_in_valid(in_valid), .i_in_data(in_data),
    .o_in_ready(b_rdy), .o_ram_address(b_addr), .o_ram_data(b_data), .o_ram_wren(b_wren),
    .o_busy(b_busy), .o_done(b_done), .o_wrapped(b_wrap), .o_count(b_cnt));

  always_comb begin
    m_rdy  = sel ? b_rdy  : a_rdy;
    m_wren = sel ? b_wren : a_wren;
    m_busy = sel ? b_busy : a_busy;
    m_done = sel ? b_done : a_done;
    m_wrap = sel ? b_wrap : a_wrap;
    m_addr = sel ? b_addr : a_addr;
    m_data = sel ? b_data : a_data;
    m_cnt  = sel ? b_cnt  : a_cnt;
  end

  typedef struct {
    logic        sel;
    logic [10:0] base;
    logic [11:0] len;
    logic [15:0] d0;
    logic        vmode;
    int          exp_n;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; circ = 1'b0; in_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int nwr, last_c, done_c, ndone, budget;
    logic cur_v;
    sel = v.sel;
    do_reset();
    base = v.base; len = v.len; circ = 1'b0; in_data = v.d0; start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_after_start", m_busy, 1);
    chk("count_after_start", m_cnt, 0);
    nwr = 0; last_c = -100; done_c = -1; ndone = 0;
    budget = v.exp_n * (v.sel ? 4 : 16) + 100;
    for (int c = 1; c <= budget; c++) begin
      cur_v = v.vmode ? (((c / 3) % 2) == 0) : 1'b1;
      in_valid = cur_v;
      step();
      if (m_wren) begin
        chk("wr_addr", m_addr, 32'((int'(v.base) + nwr) % 2048));
        chk("wr_data", m_data, 32'(16'(v.d0 + 16'(nwr))));
        if (v.vmode) chk("wr_valid_prior", cur_v, 1);
        else if (nwr > 0) chk("wr_spacing", c - last_c, v.sel ? 1 : 16);
        nwr++;
        last_c = c;
        in_data = v.d0 + 16'(nwr);
      end
      if (m_done) begin
        ndone++;
        done_c = c;
      end
      if (ndone > 0 && c >= done_c + 20) break;
    end
    in_valid = 1'b0;
    chk("n_writes", nwr, v.exp_n);
    chk("n_done", ndone, 1);
    chk("done_after_last_wren", done_c, last_c + 1);
    chk("final_count", m_cnt, v.exp_n);
    chk("oneshot_wrapped", m_wrap, 0);
    chk("idle_busy", m_busy, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nwr, extra;
    logic pulsed;

    vecs[0] = '{1'b0, 11'd0,    12'd4, 16'h1000, 1'b0, 4};
    vecs[1] = '{1'b0, 11'd2046, 12'd4, 16'h2000, 1'b0, 4};
    vecs[2] = '{1'b1, 11'd2047, 12'd3, 16'h3000, 1'b0, 3};
    vecs[3] = '{1'b1, 11'd7,    12'd1, 16'h4000, 1'b0, 1};
    vecs[4] = '{1'b1, 11'd123,  12'd0, 16'h5000, 1'b0, 2048};
    vecs[5] = '{1'b1, 11'd50,   12'd8, 16'h6000, 1'b1, 8};

    sel = 1'b0; base = '0; len = '0; in_data = '0;
    do_reset();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      chk("rst_wren", m_wren, 0);
      chk("rst_addr", m_addr, 0);
      chk("rst_data", m_data, 0);
      chk("rst_busy", m_busy, 0);
      chk("rst_done", m_done, 0);
      chk("rst_wrapped", m_wrap, 0);
      chk("rst_count", m_cnt, 0);
      chk("rst_in_ready", m_rdy, 0);
    end

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // circular capture with wrap, then stop in a would-be accept cycle
    sel = 1'b1;
    do_reset();
    base = 11'd5; len = 12'd3; circ = 1'b1; start = 1'b1;
    step();
    start = 1'b0; circ = 1'b0; in_valid = 1'b1; in_data = 16'd0; nwr = 0;
    for (int c = 0; c < 2300 && nwr < 2050; c++) begin
      step();
      if (m_wren) begin
        chk("circ_addr", m_addr, 32'((5 + nwr) % 2048));
        chk("circ_data", m_data, 32'(16'(nwr)));
        nwr++;
        in_data = 16'(nwr);
        if (nwr == 2047) chk("circ_wrapped_early", m_wrap, 0);
        if (nwr == 2048) begin
          chk("circ_wrapped", m_wrap, 1);
          chk("circ_count_full", m_cnt, 2048);
        end
      end
    end
    chk("circ_n_writes", nwr, 2050);
    chk("circ_last_addr", m_addr, 6);
    stop = 1'b1;
    #1;
    chk("stop_in_ready", m_rdy, 0);
    step();
    stop = 1'b0;
    chk("stop_blocks_accept", m_wren, 0);
    chk("stop_busy", m_busy, 0);
    step();
    chk("stop_done", m_done, 1);
    chk("stop_no_wren", m_wren, 0);
    step();
    chk("stop_done_one_cycle", m_done, 0);
    chk("circ_count_hold", m_cnt, 2048);
    chk("circ_wrapped_hold", m_wrap, 1);
    in_valid = 1'b0;

    // reset in the middle of a capture
    sel = 1'b0;
    do_reset();
    base = 11'd100; len = 12'd10; start = 1'b1;
    step();
    start = 1'b0; in_valid = 1'b1; in_data = 16'hBEEF; nwr = 0;
    for (int c = 0; c < 60 && nwr < 2; c++) begin
      step();
      if (m_wren) nwr++;
    end
    chk("midrst_pre_writes", nwr, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_wren", m_wren, 0);
    chk("midrst_addr", m_addr, 0);
    chk("midrst_data", m_data, 0);
    chk("midrst_count", m_cnt, 0);
    chk("midrst_busy", m_busy, 0);
    chk("midrst_in_ready", m_rdy, 0);
    extra = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (m_wren) extra++;
    end
    chk("midrst_no_more_wren", extra, 0);
    base = 11'd300; len = 12'd2; in_data = 16'h0300; start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_count", m_cnt, 0);
    nwr = 0;
    for (int c = 0; c < 30 && nwr < 1; c++) begin
      step();
      if (m_wren) begin
        chk("restart_addr", m_addr, 300);
        chk("restart_data", m_data, 16'h0300);
        nwr++;
      end
    end
    chk("restart_wrote", nwr, 1);
    in_valid = 1'b0;

    // start+stop together in IDLE, then start while busy is ignored
    sel = 1'b0;
    do_reset();
    base = 11'd10; len = 12'd3; start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    chk("start_beats_stop", m_busy, 1);
    in_valid = 1'b1; in_data = 16'hA000; nwr = 0; pulsed = 1'b0; extra = 0;
    for (int c = 0; c < 120; c++) begin
      step();
      start = 1'b0;
      if (m_wren) begin
        chk("busy_start_addr", m_addr, 32'(10 + nwr));
        chk("busy_start_data", m_data, 32'(16'hA000 + 16'(nwr)));
        nwr++;
        in_data = 16'hA000 + 16'(nwr);
      end
      if (m_done) extra++;
      if (nwr == 1 && !pulsed) begin
        start = 1'b1; base = 11'd500; len = 12'd1; pulsed = 1'b1;
      end
    end
    chk("busy_start_n_writes", nwr, 3);
    chk("busy_start_n_done", extra, 1);
    chk("busy_start_count", m_cnt, 3);
    in_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
